// File: rtl/lineram_dbuf.sv
// Double-buffered MARIA line RAM: one bank fills from DMA while the other plays back to video.
// A bank handed to the writer is wiped by a multi-cell-per-cycle clear engine before reuse.
module lineram_dbuf #(
   parameter int CELLS      = 160,
   parameter int ADDR_W     = 8,
   parameter int PAL_W      = 3,
   parameter int CLR_PER_CY = 4,
   localparam int CELL_W    = PAL_W + 2
) (
   input  logic              SYSCLK,
   input  logic              RESET,
   input  logic [ADDR_W-1:0] INPUT_ADDR,
   input  logic              INPUT_W,
   input  logic [PAL_W-1:0]  PALETTE,
   input  logic              PALETTE_W,
   input  logic              WM,
   input  logic              WM_W,
   input  logic [7:0]        PIXELS,
   input  logic              PIXELS_W,
   input  logic              KANGAROO,
   input  logic [1:0]        READ_MODE,
   input  logic              SWAP,
   input  logic [ADDR_W:0]   RD_COL,
   output logic [CELL_W-1:0] RD_CELL,
   output logic              RD_HALF,
   output logic [1:0]        RD_MODE,
   output logic              BUSY,
   output logic              ERR
);
   localparam int CLR_CYCLES = CELLS / CLR_PER_CY;
   localparam int CNT_W      = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
   localparam int CIDX_W     = (CELLS > 1) ? $clog2(CELLS) : 1;
   localparam logic [ADDR_W:0]  CELL_LIMIT = (ADDR_W+1)'(CELLS);
   localparam logic [ADDR_W:0]  COL_LIMIT  = (ADDR_W+1)'(2 * CELLS);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLR_CYCLES - 1);

   typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_CLEAR} state_t;

   state_t            r_state;
   state_t            w_nextState;
   logic [CNT_W-1:0]  r_clrCnt;
   logic              r_clrBoth;
   logic              r_swapQ;
   logic              r_wbank;
   logic [ADDR_W-1:0] r_ptr;
   logic [PAL_W-1:0]  r_pal;
   logic              r_wm;
   logic [1:0]        r_wrMode;

   logic              w_swapGo;
   logic              w_clrDone;
   logic              w_pixAccept;
   logic              w_swapErr;
   logic              w_swapQueue;
   logic [ADDR_W:0]   w_cellPos  [4];
   logic [CELL_W-1:0] w_cellData [4];
   logic              w_cellEn   [4];
   logic [CIDX_W-1:0] w_clrIdx   [CLR_PER_CY];

   logic [CELL_W-1:0] r_mem [2][CELLS];

   assign BUSY        = (r_state == ST_CLEAR);
   assign w_pixAccept = PIXELS_W && !BUSY;
   assign w_swapErr   = SWAP && r_swapQ;
   assign w_swapQueue = SWAP && !r_swapQ && (r_state != ST_IDLE);

   // ST_INIT exists so the first edge after reset launches a wipe of both banks.
   always_comb begin
      w_nextState = r_state;
      w_swapGo    = 1'b0;
      w_clrDone   = 1'b0;
      case (r_state)
         ST_INIT:  w_nextState = ST_CLEAR;
         ST_IDLE: begin
            if (SWAP || r_swapQ) begin
               w_swapGo    = 1'b1;
               w_nextState = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            if (r_clrCnt == CNT_LAST) begin
               w_clrDone   = 1'b1;
               w_nextState = ST_IDLE;
            end
         end
         default:  w_nextState = ST_INIT;
      endcase
   end

   // Cell positions carry an extra bit so a run past the end is dropped rather than wrapped.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         w_cellPos[k]  = {1'b0, r_ptr} + (ADDR_W+1)'(k);
         w_cellData[k] = '0;
         w_cellEn[k]   = 1'b0;
      end
      if (!r_wm) begin
         for (int k = 0; k < 4; k++) begin
            w_cellData[k] = {r_pal, PIXELS[7-2*k -: 2]};
            w_cellEn[k]   = w_pixAccept && (KANGAROO || (PIXELS[7-2*k -: 2] != 2'b00))
                            && (w_cellPos[k] < CELL_LIMIT);
         end
      end else begin
         w_cellData[0][CELL_W-1] = r_pal[PAL_W-1];
         w_cellData[0][3:0]      = {PIXELS[3:2], PIXELS[7:6]};
         w_cellEn[0]             = w_pixAccept && (KANGAROO || (PIXELS[7:6] != 2'b00))
                                   && (w_cellPos[0] < CELL_LIMIT);
         w_cellData[1][CELL_W-1] = r_pal[PAL_W-1];
         w_cellData[1][3:0]      = {PIXELS[1:0], PIXELS[5:4]};
         w_cellEn[1]             = w_pixAccept && (KANGAROO || (PIXELS[5:4] != 2'b00))
                                   && (w_cellPos[1] < CELL_LIMIT);
      end
   end

   always_comb begin
      for (int j = 0; j < CLR_PER_CY; j++)
         w_clrIdx[j] = CIDX_W'(r_clrCnt) * CIDX_W'(CLR_PER_CY) + CIDX_W'(j);
   end

   // Pixel writes never overlap clearing, since writes are refused while BUSY.
   always_ff @(posedge SYSCLK) begin
      if (r_state == ST_CLEAR) begin
         for (int b = 0; b < 2; b++) begin
            if (r_clrBoth || (1'(b) == r_wbank)) begin
               for (int j = 0; j < CLR_PER_CY; j++)
                  r_mem[1'(b)][w_clrIdx[j]] <= '0;
            end
         end
      end
      for (int k = 0; k < 4; k++) begin
         if (w_cellEn[k])
            r_mem[r_wbank][w_cellPos[k][CIDX_W-1:0]] <= w_cellData[k];
      end
   end

   always_ff @(posedge SYSCLK or posedge RESET) begin
      if (RESET) begin
         r_state   <= ST_INIT;
         r_clrCnt  <= '0;
         r_clrBoth <= 1'b1;
         r_swapQ   <= 1'b0;
         r_wbank   <= 1'b0;
         r_ptr     <= '0;
         r_pal     <= '0;
         r_wm      <= 1'b0;
         r_wrMode  <= 2'b00;
         RD_CELL   <= '0;
         RD_HALF   <= 1'b0;
         RD_MODE   <= 2'b00;
         ERR       <= 1'b0;
      end else begin
         r_state <= w_nextState;

         if ((r_state == ST_CLEAR) && !w_clrDone)
            r_clrCnt <= r_clrCnt + 1'b1;
         else
            r_clrCnt <= '0;

         if (w_swapGo)
            r_clrBoth <= 1'b0;

         if (w_swapGo)
            r_swapQ <= 1'b0;
         else if (w_swapQueue)
            r_swapQ <= 1'b1;

         if (INPUT_W)
            r_ptr <= INPUT_ADDR;
         else if (w_pixAccept)
            r_ptr <= r_ptr + (r_wm ? ADDR_W'(2) : ADDR_W'(4));

         if (PALETTE_W)
            r_pal <= PALETTE;
         if (WM_W)
            r_wm <= WM;

         // A write landing on the swap edge belongs to the outgoing bank, so its mode goes with it.
         if (w_swapGo) begin
            r_wbank  <= ~r_wbank;
            r_wrMode <= 2'b00;
            RD_MODE  <= w_pixAccept ? READ_MODE : r_wrMode;
         end else if (w_pixAccept) begin
            r_wrMode <= READ_MODE;
         end

         if ((PIXELS_W && BUSY) || w_swapErr)
            ERR <= 1'b1;

         RD_CELL <= (RD_COL < COL_LIMIT) ? r_mem[~r_wbank][RD_COL[CIDX_W:1]] : '0;
         RD_HALF <= RD_COL[0];
      end
   end
endmodule

// File: tb/tb_lineram_dbuf.sv
// Randomised and directed bench for lineram_dbuf against a cell-array reference model.
// The model treats a bank clear as instantaneous and only tracks how long BUSY lasts.
module tb_lineram_dbuf;
   localparam int CELLS      = 160;
   localparam int CLR_CYCLES = 40;

   logic       SYSCLK = 1'b0;
   logic       RESET  = 1'b1;
   logic [7:0] INPUT_ADDR = '0;
   logic       INPUT_W = 1'b0;
   logic [2:0] PALETTE = '0;
   logic       PALETTE_W = 1'b0;
   logic       WM = 1'b0;
   logic       WM_W = 1'b0;
   logic [7:0] PIXELS = '0;
   logic       PIXELS_W = 1'b0;
   logic       KANGAROO = 1'b0;
   logic [1:0] READ_MODE = '0;
   logic       SWAP = 1'b0;
   logic [8:0] RD_COL = '0;
   logic [4:0] RD_CELL;
   logic       RD_HALF;
   logic [1:0] RD_MODE;
   logic       BUSY;
   logic       ERR;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic       ldAddr;
      logic [7:0] addr;
      logic       ldPal;
      logic [2:0] pal;
      logic       ldWm;
      logic       wm;
      logic       pixW;
      logic [7:0] pix;
      logic       kang;
      logic [1:0] rmode;
      logic       swap;
      logic [8:0] col;
   } stim_t;

   lineram_dbuf dut (
      .SYSCLK(SYSCLK), .RESET(RESET),
      .INPUT_ADDR(INPUT_ADDR), .INPUT_W(INPUT_W),
      .PALETTE(PALETTE), .PALETTE_W(PALETTE_W),
      .WM(WM), .WM_W(WM_W),
      .PIXELS(PIXELS), .PIXELS_W(PIXELS_W),
      .KANGAROO(KANGAROO), .READ_MODE(READ_MODE),
      .SWAP(SWAP), .RD_COL(RD_COL),
      .RD_CELL(RD_CELL), .RD_HALF(RD_HALF), .RD_MODE(RD_MODE),
      .BUSY(BUSY), .ERR(ERR)
   );

   always #5 SYSCLK = ~SYSCLK;

   int mBank [2][CELLS];
   int mPtr, mPal, mWm, mWbank, mMode, mDispMode, mBusyLeft, mErr, mRdCell, mRdHalf;
   bit mQueued, mInitPending, mInitClr, mRdValid;

   task automatic checkOutput(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void zeroBank(input int b);
      for (int i = 0; i < CELLS; i++) mBank[b][i] = 0;
   endfunction

   function automatic void modelReset();
      mPtr = 0; mPal = 0; mWm = 0; mWbank = 0; mMode = 0; mDispMode = 0;
      mBusyLeft = 0; mErr = 0; mRdCell = 0; mRdHalf = 0;
      mQueued = 0; mInitPending = 1; mInitClr = 1; mRdValid = 1;
   endfunction

   function automatic void modelWrite();
      int pix, lo, hi, val;
      pix = int'(PIXELS);
      if (mWm == 0) begin
         for (int k = 0; k < 4; k++) begin
            lo = (pix >> (6 - 2*k)) & 3;
            if ((lo != 0 || KANGAROO) && (mPtr + k < CELLS))
               mBank[mWbank][mPtr + k] = mPal * 4 + lo;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            lo  = (pix >> (6 - 2*k)) & 3;
            hi  = (pix >> (2 - 2*k)) & 3;
            val = (mPal / 4) * 16 + hi * 4 + lo;
            if ((lo != 0 || KANGAROO) && (mPtr + k < CELLS))
               mBank[mWbank][mPtr + k] = val;
         end
      end
   endfunction

   function automatic void modelStep();
      bit wasBusy, idle, go;
      int col;
      col      = int'(RD_COL);
      mRdValid = !mInitClr;
      mRdCell  = (col < 2*CELLS) ? mBank[mWbank ^ 1][col / 2] : 0;
      mRdHalf  = col % 2;
      wasBusy  = mBusyLeft > 0;
      idle     = !wasBusy && !mInitPending;
      go       = idle && (SWAP || mQueued);
      if (SWAP && mQueued) mErr = 1;
      else if (SWAP && !idle) mQueued = 1;
      if (go) mQueued = 0;
      if (PIXELS_W) begin
         if (wasBusy) mErr = 1;
         else begin
            modelWrite();
            mMode = int'(READ_MODE);
            mPtr  = (mPtr + ((mWm != 0) ? 2 : 4)) % 256;
         end
      end
      if (INPUT_W)   mPtr = int'(INPUT_ADDR);
      if (PALETTE_W) mPal = int'(PALETTE);
      if (WM_W)      mWm  = int'(WM);
      if (wasBusy) begin
         mBusyLeft--;
         if (mBusyLeft == 0) mInitClr = 0;
      end
      if (go) begin
         mDispMode = mMode;
         mMode     = 0;
         mWbank    = mWbank ^ 1;
         zeroBank(mWbank);
         mBusyLeft = CLR_CYCLES;
      end
      if (mInitPending) begin
         mInitPending = 0;
         zeroBank(0);
         zeroBank(1);
         mBusyLeft = CLR_CYCLES;
      end
   endfunction

   task automatic compareAll();
      checkOutput("busy", int'(BUSY), (mBusyLeft > 0) ? 1 : 0);
      checkOutput("err", int'(ERR), mErr);
      checkOutput("rd_mode", int'(RD_MODE), mDispMode);
      checkOutput("rd_half", int'(RD_HALF), mRdHalf);
      if (mRdValid) checkOutput("rd_cell", int'(RD_CELL), mRdCell);
   endtask

   always @(posedge SYSCLK) begin
      if (RESET) modelReset();
      else modelStep();
      #1;
      compareAll();
   end

   function automatic stim_t idleStim(input logic [8:0] col);
      stim_t s;
      s     = '0;
      s.col = col;
      return s;
   endfunction

   task automatic applyStimulus(input stim_t s);
      INPUT_W = s.ldAddr;  INPUT_ADDR = s.addr;
      PALETTE_W = s.ldPal; PALETTE = s.pal;
      WM_W = s.ldWm;       WM = s.wm;
      PIXELS_W = s.pixW;   PIXELS = s.pix;
      KANGAROO = s.kang;   READ_MODE = s.rmode;
      SWAP = s.swap;       RD_COL = s.col;
      @(negedge SYSCLK);
      INPUT_W = 1'b0; PALETTE_W = 1'b0; WM_W = 1'b0;
      PIXELS_W = 1'b0; SWAP = 1'b0; KANGAROO = 1'b0;
   endtask

   task automatic readCheck(input string name, input int col, input int expCell, input int expHalf);
      applyStimulus(idleStim(9'(col)));
      checkOutput(name, int'(RD_CELL), expCell);
      checkOutput({name, "_half"}, int'(RD_HALF), expHalf);
   endtask

   task automatic countBusy(output int n);
      n = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge SYSCLK);
         if (BUSY) n++;
         else if (n > 0) break;
      end
   endtask

   task automatic countLow(output int n);
      n = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge SYSCLK);
         if (!BUSY) n++;
         else if (n > 0) break;
      end
   endtask

   task automatic waitIdle();
      for (int i = 0; i < 200 && BUSY; i++) @(negedge SYSCLK);
      checkOutput("wait_idle", int'(BUSY), 0);
   endtask

   task automatic loadRegs(input int ptr, input int pal, input int wm);
      stim_t s;
      s = idleStim('0);
      s.ldAddr = 1'b1; s.addr = 8'(ptr);
      s.ldPal  = 1'b1; s.pal  = 3'(pal);
      s.ldWm   = 1'b1; s.wm   = 1'(wm);
      applyStimulus(s);
   endtask

   task automatic writePix(input int pix, input bit kang, input int rmode);
      stim_t s;
      s = idleStim('0);
      s.pixW = 1'b1; s.pix = 8'(pix); s.kang = kang; s.rmode = 2'(rmode);
      applyStimulus(s);
   endtask

   task automatic doSwap();
      stim_t s;
      s = idleStim('0);
      s.swap = 1'b1;
      applyStimulus(s);
   endtask

   initial begin
      stim_t s;
      int n;

      repeat (3) @(negedge SYSCLK);
      checkOutput("reset_busy", int'(BUSY), 0);
      checkOutput("reset_err", int'(ERR), 0);
      checkOutput("reset_cell", int'(RD_CELL), 0);
      checkOutput("reset_mode", int'(RD_MODE), 0);
      RESET = 1'b0;
      countBusy(n);
      checkOutput("init_busy_len", n, 40);
      for (int c = 0; c < 320; c += 53) readCheck("init_read_zero", c, 0, c % 2);

      loadRegs(10, 5, 0);
      writePix(8'hE4, 1'b0, 2);
      doSwap();
      checkOutput("swap_busy", int'(BUSY), 1);
      readCheck("wm0_cell10", 20, 8'h17, 0);
      readCheck("wm0_cell11", 22, 8'h16, 0);
      readCheck("wm0_cell12", 24, 8'h15, 0);
      readCheck("wm0_cell13_skip", 26, 8'h00, 0);
      readCheck("col21_right", 21, 8'h17, 1);
      checkOutput("rd_mode_2", int'(RD_MODE), 2);
      waitIdle();

      loadRegs(32, 4, 1);
      writePix(8'h9C, 1'b0, 1);
      writePix(8'h0C, 1'b1, 1);
      writePix(8'h0C, 1'b0, 1);
      doSwap();
      readCheck("wm1_cell32", 64, 8'h1E, 0);
      readCheck("wm1_cell33", 66, 8'h11, 0);
      readCheck("kang_cell34", 68, 8'h1C, 0);
      readCheck("kang_cell35", 70, 8'h10, 0);
      readCheck("transp_cell36", 72, 8'h00, 0);
      readCheck("transp_cell37", 74, 8'h00, 0);
      checkOutput("rd_mode_1", int'(RD_MODE), 1);
      waitIdle();

      loadRegs(158, 2, 0);
      writePix(8'hFF, 1'b0, 3);
      writePix(8'hFF, 1'b0, 3);
      s = idleStim('0); s.ldAddr = 1'b1; s.addr = 8'd254;
      applyStimulus(s);
      writePix(8'hFF, 1'b0, 3);
      writePix(8'hFF, 1'b0, 3);
      doSwap();
      readCheck("edge_cell158", 316, 8'h0B, 0);
      readCheck("edge_cell159", 319, 8'h0B, 1);
      readCheck("wrap_cell2", 4, 8'h0B, 0);
      readCheck("wrap_cell5", 10, 8'h0B, 0);
      readCheck("wrap_cell6", 12, 8'h00, 0);
      readCheck("nowrap_cell0", 0, 8'h00, 0);
      readCheck("col320_zero", 320, 8'h00, 0);
      readCheck("col511_zero", 511, 8'h00, 1);
      checkOutput("rd_mode_3", int'(RD_MODE), 3);
      waitIdle();

      doSwap();
      doSwap();
      checkOutput("queued_no_err", int'(ERR), 0);
      doSwap();
      checkOutput("queue_overflow_err", int'(ERR), 1);
      countLow(n);
      checkOutput("queued_gap", n, 1);
      checkOutput("queued_busy", int'(BUSY), 1);

      repeat (5) applyStimulus(idleStim('0));
      RESET = 1'b1;
      repeat (2) @(negedge SYSCLK);
      checkOutput("midreset_busy", int'(BUSY), 0);
      checkOutput("midreset_err", int'(ERR), 0);
      checkOutput("midreset_mode", int'(RD_MODE), 0);
      RESET = 1'b0;
      applyStimulus(idleStim('0));
      applyStimulus(idleStim('0));
      writePix(8'hFF, 1'b0, 0);
      checkOutput("busy_write_err", int'(ERR), 1);
      waitIdle();

      for (int cyc = 0; cyc < 4000; cyc++) begin
         if ($urandom_range(1499) == 0) begin
            RESET = 1'b1;
            repeat (2) @(negedge SYSCLK);
            RESET = 1'b0;
         end
         s        = idleStim(9'($urandom_range(511)));
         s.ldAddr = ($urandom_range(9) == 0);
         s.addr   = 8'($urandom);
         s.ldPal  = ($urandom_range(7) == 0);
         s.pal    = 3'($urandom);
         s.ldWm   = ($urandom_range(7) == 0);
         s.wm     = 1'($urandom);
         s.pixW   = ($urandom_range(2) == 0);
         s.pix    = 8'($urandom);
         s.kang   = 1'($urandom);
         s.rmode  = 2'($urandom);
         s.swap   = ($urandom_range(44) == 0);
         applyStimulus(s);
      end

      repeat (2) @(negedge SYSCLK);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
